// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and lane helpers for the load/store sequencer
package lsu_pkg;

    localparam int BYTES_PER_WORD = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} lsu_state_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Byte lanes touched across two consecutive words; bits [7:4] belong to the next word.
    function automatic logic [7:0] lane_mask(input logic [1:0] size_code, input logic [1:0] off);
        logic [7:0] base;
        case (size_code)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/lsu_ctrl_load_extend.sv
// rtl/lsu_ctrl_load_extend.sv - sign/zero extension of the right-aligned load value
module load_extend
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] raw,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = raw;
        case (funct3)
            F3_LB:   result = {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
            F3_LH:   result = {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
            F3_LBU:  result = {{(DATA_WIDTH-8){1'b0}}, raw[7:0]};
            F3_LHU:  result = {{(DATA_WIDTH-16){1'b0}}, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer: word beats with byte enables, split misaligned accesses
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [3:0]               mem_be,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    lsu_state_t                state_q, state_d;
    logic                      we_q, we_d;
    logic [2:0]                funct3_q, funct3_d;
    logic [1:0]                off_q, off_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     lo_q, lo_d;
    logic                      req_ready_q, req_ready_d;
    logic                      resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]     resp_rdata_q, resp_rdata_d;
    logic                      resp_err_q, resp_err_d;
    logic                      mem_req_q, mem_req_d;
    logic                      mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [3:0]                mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;

    logic [7:0]                req_mask, cur_mask;
    logic [2*DATA_WIDTH-1:0]   req_lanes, cur_lanes;
    logic [DATA_WIDTH-1:0]     lo_src, hi_src, ext_result;
    logic [2*DATA_WIDTH-1:0]   raw_wide;

    assign req_mask  = lane_mask(req_funct3[1:0], req_addr[1:0]);
    assign cur_mask  = lane_mask(funct3_q[1:0], off_q);
    assign req_lanes = {{DATA_WIDTH{1'b0}}, req_wdata} << {req_addr[1:0], 3'b000};
    assign cur_lanes = {{DATA_WIDTH{1'b0}}, wdata_q} << {off_q, 3'b000};

    // The response is registered on the final ack, so the word arriving this cycle is used directly.
    assign lo_src   = (state_q == BEAT0) ? mem_rdata : lo_q;
    assign hi_src   = (state_q == BEAT1) ? mem_rdata : '0;
    assign raw_wide = {hi_src, lo_src} >> {off_q, 3'b000};

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
        .raw    (raw_wide[DATA_WIDTH-1:0]),
        .funct3 (funct3_q),
        .result (ext_result)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    funct3_d    = req_funct3;
                    off_d       = req_addr[1:0];
                    wdata_d     = req_wdata;
                    lo_d        = '0;
                    req_ready_d = 1'b0;
                    if (f3_legal(req_we, req_funct3)) begin
                        state_d     = BEAT0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
                        mem_be_d    = req_mask[3:0];
                        mem_wdata_d = req_lanes[DATA_WIDTH-1:0];
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end
                end
            end
            BEAT0, BEAT1: begin
                if (mem_ack) begin
                    if (state_q == BEAT0) begin
                        lo_d = mem_rdata;
                    end
                    if (state_q == BEAT0 && cur_mask[7:4] != 4'b0000) begin
                        state_d     = BEAT1;
                        mem_addr_d  = mem_addr_q + ADDRESS_WIDTH'(BYTES_PER_WORD);
                        mem_be_d    = cur_mask[7:4];
                        mem_wdata_d = cur_lanes[2*DATA_WIDTH-1:DATA_WIDTH];
                    end else begin
                        state_d      = RESP;
                        mem_req_d    = 1'b0;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = '0;
                        mem_be_d     = 4'b0000;
                        mem_wdata_d  = '0;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = we_q ? '0 : ext_result;
                    end
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            lo_q         <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int compared = 0;
    int mismatched = 0;

    lsu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a negedge while IDLE; returns on the negedge of the cycle after acceptance.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic beat(input int wait_cycles, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic exp_we, input logic [31:0] exp_wdata, input logic [31:0] rdata);
        for (int i = 0; i < wait_cycles; i++) begin
            chk("wait_mem_req", {31'b0, mem_req}, 32'd1);
            chk("wait_mem_addr", mem_addr, exp_addr);
            chk("wait_mem_be", {28'b0, mem_be}, {28'b0, exp_be});
            chk("wait_resp_valid", {31'b0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        chk("mem_req", {31'b0, mem_req}, 32'd1);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", {28'b0, mem_be}, {28'b0, exp_be});
        chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
        chk("mem_wdata", mem_wdata, exp_wdata);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic resp(input logic [31:0] exp_rdata, input logic exp_err);
        chk("resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
        chk("resp_mem_req", {31'b0, mem_req}, 32'd0);
        chk("resp_req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("resp_pulse_end", {31'b0, resp_valid}, 32'd0);
        chk("resp_rdata_hold", resp_rdata, exp_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // lw 0x100 aligned
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        beat(0, 32'h0000_0100, 4'b1111, 1'b0, 32'h0, 32'h4433_2211);
        resp(32'h4433_2211, 1'b0);

        // lw 0x102 split
        issue(1'b0, 3'b010, 32'h0000_0102, 32'h0);
        beat(0, 32'h0000_0100, 4'b1100, 1'b0, 32'h0, 32'h4433_2211);
        beat(0, 32'h0000_0104, 4'b0011, 1'b0, 32'h0, 32'h8877_6655);
        resp(32'h6655_4433, 1'b0);

        // lb 0x103 sign extension
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        beat(0, 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 32'h8000_0000);
        resp(32'hFFFF_FF80, 1'b0);

        // lhu 0x103 split, zero extension
        issue(1'b0, 3'b101, 32'h0000_0103, 32'h0);
        beat(0, 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 32'h4433_2211);
        beat(0, 32'h0000_0104, 4'b0001, 1'b0, 32'h0, 32'h8877_6655);
        resp(32'h0000_5544, 1'b0);

        // sh 0x103 split store
        issue(1'b1, 3'b001, 32'h0000_0103, 32'h0000_BEEF);
        beat(0, 32'h0000_0100, 4'b1000, 1'b1, 32'hEF00_0000, 32'h0);
        beat(0, 32'h0000_0104, 4'b0001, 1'b1, 32'h0000_00BE, 32'h0);
        resp(32'h0, 1'b0);

        // lw 0x106 with 3-cycle ack delay per beat
        issue(1'b0, 3'b010, 32'h0000_0106, 32'h0);
        beat(3, 32'h0000_0104, 4'b1100, 1'b0, 32'h0, 32'h8877_6655);
        beat(3, 32'h0000_0108, 4'b0011, 1'b0, 32'h0, 32'hCCBB_AA99);
        resp(32'hAA99_8877, 1'b0);

        // reset asserted during the second beat
        issue(1'b0, 3'b010, 32'h0000_0102, 32'h0);
        beat(0, 32'h0000_0100, 4'b1100, 1'b0, 32'h0, 32'h4433_2211);
        chk("beat1_before_rst", {31'b0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_async_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        chk("rst_no_resp", {31'b0, resp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_no_resp", {31'b0, resp_valid}, 32'd0);
        chk("post_rst_mem_req", {31'b0, mem_req}, 32'd0);
        issue(1'b0, 3'b000, 32'h0000_0100, 32'h0);
        beat(0, 32'h0000_0100, 4'b0001, 1'b0, 32'h0, 32'h4433_2211);
        resp(32'h0000_0011, 1'b0);

        // illegal store funct3=100
        issue(1'b1, 3'b100, 32'h0000_0200, 32'h1234_5678);
        resp(32'h0, 1'b1);

        // illegal load funct3=011
        issue(1'b0, 3'b011, 32'h0000_0200, 32'h0);
        resp(32'h0, 1'b1);

        // lw 0xFFFFFFFE wraps to address 0
        issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
        beat(0, 32'hFFFF_FFFC, 4'b1100, 1'b0, 32'h0, 32'h4433_2211);
        beat(0, 32'h0000_0000, 4'b0011, 1'b0, 32'h0, 32'h8877_6655);
        resp(32'h6655_4433, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
